// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and 512-bit block output bundle of the SHA-256 message padder.
// The slave modport is the padder's view; master is the environment's view.
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Byte-serial message to padded big-endian 512-bit SHA-256 blocks (0x80, zero fill, 64-bit length),
// tagging each block as first/last of its message.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64
) (
  input logic                 clock,
  input logic                 resetn,
  sha256_msg_padder_if.slave  bus
);

  typedef enum logic [2:0] {FILL, PAD, PAD0, LENB, EMIT} state_t;

  state_t            state, state_n, ret, ret_n;
  logic [0:63][7:0]  blk_buf;
  logic [5:0]        ptr;
  logic [LEN_W-1:0]  bitcnt;
  logic [63:0]       len64;
  logic              first_pend, mark, run;
  logic              in_ready, acc, emit;

  assign len64    = 64'(bitcnt);
  assign in_ready = run && (state == FILL);
  assign acc      = bus.in_valid && in_ready;
  assign emit     = (state == EMIT) && bus.blk_ready;

  assign bus.in_ready  = in_ready;
  assign bus.blk_valid = (state == EMIT);
  assign bus.blk_data  = blk_buf;
  assign bus.blk_first = (state == EMIT) && first_pend;
  assign bus.blk_last  = (state == EMIT) && mark;

  // Holds in_ready low while reset is asserted even though the reset state is FILL.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) run <= 1'b0;
    else         run <= 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FILL;
      ret   <= FILL;
    end else begin
      state <= state_n;
      ret   <= ret_n;
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret;
    unique case (state)
      FILL: begin
        if (acc) begin
          if (ptr == 6'd63) begin
            state_n = EMIT;
            ret_n   = bus.in_last ? PAD0 : FILL;
          end else if (bus.in_last) begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        state_n = EMIT;
        ret_n   = (ptr <= 6'd55) ? FILL : LENB;
      end
      PAD0, LENB: begin
        state_n = EMIT;
        ret_n   = FILL;
      end
      EMIT: begin
        if (bus.blk_ready) state_n = ret;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blk_buf    <= '0;
      ptr        <= '0;
      bitcnt     <= '0;
      first_pend <= 1'b1;
      mark       <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (acc) begin
            blk_buf[ptr] <= bus.in_data;
            ptr          <= ptr + 6'd1;
            bitcnt       <= bitcnt + LEN_W'(8);
          end
        end
        PAD: begin
          // When the 0x80 lands in bytes 56..63 the length moves to a separate LENB block.
          blk_buf[ptr] <= 8'h80;
          if (ptr <= 6'd55) begin
            blk_buf[56:63] <= len64;
            mark           <= 1'b1;
          end
        end
        PAD0: begin
          blk_buf <= {8'h80, 440'b0, len64};
          mark    <= 1'b1;
        end
        LENB: begin
          blk_buf <= {448'b0, len64};
          mark    <= 1'b1;
        end
        EMIT: begin
          if (emit) begin
            first_pend <= mark;
            blk_buf    <= '0;
            ptr        <= '0;
            mark       <= 1'b0;
            if (mark) bitcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized scoreboard bench for sha256_msg_padder against a FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] msg[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         rdy_mode = 0;   // 0 random, 1 stall, 2 always ready

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Padding from the standard rule: append 0x80, zero until length = 56 mod 64, append 64-bit bit count.
  function automatic void model_push();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] d;
    blk_t         b;
    int unsigned  nb;
    p = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int unsigned i = 0; i < 8; i++) p.push_back(bl[63 - 8*i -: 8]);
    nb = p.size() / 64;
    for (int unsigned k = 0; k < nb; k++) begin
      d = '0;
      for (int unsigned j = 0; j < 64; j++) d = {d[503:0], p[k*64 + j]};
      b.d = d;
      b.f = (k == 0);
      b.l = (k == nb - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void mk_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endfunction

  function automatic void mk_fill(input int n, input logic [7:0] v);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(v);
  endfunction

  function automatic void mk_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endfunction

  // Monitor: choose blk_ready for the coming edge, then score whatever the DUT presents.
  always @(negedge clock) begin
    if (!resetn) begin
      bus.blk_ready = 1'b0;
    end else begin
      case (rdy_mode)
        1:       bus.blk_ready = 1'b0;
        2:       bus.blk_ready = 1'b1;
        default: bus.blk_ready = ($urandom_range(1) == 1);
      endcase
      if (mon_en && bus.blk_valid) begin
        chk("in_ready_in_emit", 512'(bus.in_ready), 512'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_block", 512'(bus.blk_valid), 512'd0);
        end else begin
          chk("blk_data",  bus.blk_data,       exp_q[0].d);
          chk("blk_first", 512'(bus.blk_first), 512'(exp_q[0].f));
          chk("blk_last",  512'(bus.blk_last),  512'(exp_q[0].l));
          if (bus.blk_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_msg(input bit gaps, input bit partial);
    int i = 0;
    int cyc = 0;
    if (!partial) model_push();
    while (i < msg.size()) begin
      @(negedge clock);
      bus.in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      bus.in_data  = bus.in_valid ? msg[i] : 8'($urandom);
      bus.in_last  = bus.in_valid && !partial && (i == msg.size() - 1);
      if (bus.in_valid && bus.in_ready) i++;
      if (++cyc > 20000) begin
        chk("send_timeout", 512'(i), 512'(msg.size()));
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    chk("drain", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic wait_blk_valid();
    int cyc = 0;
    while (!bus.blk_valid && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    chk("wait_blk_valid", 512'(bus.blk_valid), 512'd1);
  endtask

  task automatic reset_pulse();
    #2 resetn = 1'b0;
    #1;
    chk("rst_in_ready",  512'(bus.in_ready),  512'd0);
    chk("rst_blk_valid", 512'(bus.blk_valid), 512'd0);
    chk("rst_blk_data",  bus.blk_data,        512'd0);
    chk("rst_blk_first", 512'(bus.blk_first), 512'd0);
    chk("rst_blk_last",  512'(bus.blk_last),  512'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int lens[13] = '{1, 2, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 129};

    resetn       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #3;
    chk("reset_in_ready",  512'(bus.in_ready),  512'd0);
    chk("reset_blk_valid", 512'(bus.blk_valid), 512'd0);
    chk("reset_blk_data",  bus.blk_data,        512'd0);
    chk("reset_blk_first", 512'(bus.blk_first), 512'd0);
    chk("reset_blk_last",  512'(bus.blk_last),  512'd0);
    #9 resetn = 1'b1;
    #1 chk("in_ready_before_edge", 512'(bus.in_ready), 512'd0);
    @(negedge clock);
    chk("in_ready_after_edge", 512'(bus.in_ready), 512'd1);
    mon_en = 1'b1;

    mk_str("hello world"); send_msg(1'b0, 1'b0); idle(); drain();
    mk_str("abc");         send_msg(1'b1, 1'b0); idle(); drain();
    mk_fill(55, 8'h61);    send_msg(1'b0, 1'b0); idle(); drain();
    mk_fill(56, 8'h61);    send_msg(1'b1, 1'b0); idle(); drain();
    mk_fill(64, 8'h61);    send_msg(1'b0, 1'b0); idle(); drain();

    // Stall in EMIT: block held, no byte taken; then two back-to-back "abc" messages.
    rdy_mode = 1;
    mk_str("abc"); send_msg(1'b0, 1'b0); idle();
    wait_blk_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      bus.in_last  = 1'b1;
      chk("stall_in_ready", 512'(bus.in_ready), 512'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rdy_mode = 2;
    mk_str("abc"); send_msg(1'b0, 1'b0);
    mk_str("abc"); send_msg(1'b0, 1'b0);
    idle(); drain();
    rdy_mode = 0;

    // Reset after 30 bytes of an unfinished message.
    mk_rand(30); send_msg(1'b1, 1'b1); idle();
    repeat (3) @(negedge clock);
    reset_pulse();
    mk_str("abc"); send_msg(1'b0, 1'b0); idle(); drain();

    // Reset while a full block waits in EMIT.
    mon_en = 1'b0;
    rdy_mode = 1;
    mk_fill(64, 8'h5a); send_msg(1'b0, 1'b1); idle();
    wait_blk_valid();
    @(negedge clock);
    reset_pulse();
    mon_en = 1'b1;
    rdy_mode = 0;
    mk_str("abc"); send_msg(1'b1, 1'b0); idle(); drain();

    // Randomized messages around block boundaries and arbitrary lengths.
    for (int m = 0; m < 40; m++) begin
      if ($urandom_range(1) == 1) mk_rand(lens[$urandom_range(12)]);
      else                        mk_rand($urandom_range(200, 1));
      send_msg($urandom_range(1) == 1, 1'b0);
      if ($urandom_range(3) == 0) idle();
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
